// File: rtl/pc_unit.sv
// pc_unit: program counter register and next-PC selection for the single-cycle RV32I core.
// Ports: clk, rst_n (async active-low); NexttoPc (PC+4 from pcplus4); branchTaken/branchTarget,
// jumpTaken/jumpTarget (redirects, jump wins); stall; halt; resume; trapAck;
// fromPc (current PC), pcValid, trapPending, trapCause (01 branch, 10 jump), trapEpc,
// retireCount (only when PC_PERF_CNT_EN is defined).
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] NexttoPc,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  input  logic        trapAck,
  output logic [31:0] fromPc,
  output logic        pcValid,
  output logic        trapPending,
  output logic [1:0]  trapCause,
  output logic [31:0] trapEpc
`ifdef PC_PERF_CNT_EN
  , output logic [31:0] retireCount
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED, TRAP} state_t;
  state_t state;
  logic [31:0] candPc;
  logic misaligned;
  logic retire;
  // Only redirect targets are checked; NexttoPc is aligned by construction.
  always_comb begin
    candPc = jumpTaken ? jumpTarget : branchTaken ? branchTarget : NexttoPc;
    misaligned = (jumpTaken || branchTaken) && (candPc[1:0] != 2'b00);
    retire = !stall && ((state == RUN && !misaligned) || state == TRAP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      fromPc <= RESET_VECTOR;
      pcValid <= 1'b0;
      trapPending <= 1'b0;
      trapCause <= 2'b00;
      trapEpc <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          pcValid <= 1'b1;
        end
        RUN: if (!stall) begin
          if (misaligned) begin
            state <= TRAP;
            fromPc <= TRAP_VECTOR;
            trapEpc <= fromPc;
            trapCause <= jumpTaken ? 2'b10 : 2'b01;
            trapPending <= 1'b1;
          end else if (halt) begin
            state <= HALTED;
            pcValid <= 1'b0;
          end else begin
            fromPc <= candPc;
          end
        end
        // A misaligned target inside the handler is taken unchecked and ends the trap.
        TRAP: if (!stall) begin
          fromPc <= candPc;
          if (trapAck || misaligned) begin
            state <= RUN;
            trapPending <= 1'b0;
            trapCause <= 2'b00;
          end
        end
        HALTED: if (resume) begin
          state <= RUN;
          fromPc <= NexttoPc;
          pcValid <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end
`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retireCount <= 32'h0;
    else if (retire) retireCount <= retireCount + 32'd1;
  end
`else
  logic unusedRetire;
  assign unusedRetire = retire;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; expectations are queued with each stimulus and popped after the edge.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] nextPc;
  logic branchTaken = 1'b0, jumpTaken = 1'b0, stall = 1'b0, halt = 1'b0, resume = 1'b0, trapAck = 1'b0;
  logic [31:0] branchTarget = 32'h0, jumpTarget = 32'h0;
  logic [31:0] fromPc, trapEpc;
  logic pcValid, trapPending;
  logic [1:0] trapCause;
`ifdef PC_PERF_CNT_EN
  logic [31:0] retireCount;
`endif
  int nChecks = 0;
  int nPass = 0;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic [1:0]  cause;
    logic [31:0] epc;
    int          cnt;
  } exp_t;
  exp_t expQ[$];
  string tagQ[$];

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .NexttoPc(nextPc),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jumpTaken(jumpTaken), .jumpTarget(jumpTarget),
    .stall(stall), .halt(halt), .resume(resume), .trapAck(trapAck),
    .fromPc(fromPc), .pcValid(pcValid), .trapPending(trapPending),
    .trapCause(trapCause), .trapEpc(trapEpc)
`ifdef PC_PERF_CNT_EN
    , .retireCount(retireCount)
`endif
  );

  // pcplus4 stand-in
  assign nextPc = fromPc + 32'd4;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  task automatic compareAll(input string tag, input exp_t e);
    check({tag, "_pc"}, fromPc, e.pc);
    check({tag, "_valid"}, {31'b0, pcValid}, {31'b0, e.valid});
    check({tag, "_pend"}, {31'b0, trapPending}, {31'b0, e.pend});
    check({tag, "_cause"}, {30'b0, trapCause}, {30'b0, e.cause});
    check({tag, "_epc"}, trapEpc, e.epc);
`ifdef PC_PERF_CNT_EN
    if (e.cnt >= 0) check({tag, "_cnt"}, retireCount, e.cnt);
`endif
  endtask

  // Drive one cycle of stimulus, queue its expected post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input logic j, input logic [31:0] jt, input logic b,
                      input logic [31:0] bt, input logic st, input logic h, input logic r, input logic a,
                      input logic [31:0] ePc, input logic eV, input logic eP, input logic [1:0] eC,
                      input logic [31:0] eEpc, input int eCnt);
    exp_t e;
    jumpTaken = j; jumpTarget = jt; branchTaken = b; branchTarget = bt;
    stall = st; halt = h; resume = r; trapAck = a;
    e.pc = ePc; e.valid = eV; e.pend = eP; e.cause = eC; e.epc = eEpc; e.cnt = eCnt;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    jumpTaken = 0; branchTaken = 0; stall = 0; halt = 0; resume = 0; trapAck = 0;
    if (expQ.size() == 0) begin
      nChecks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else compareAll(tagQ.pop_front(), expQ.pop_front());
  endtask

  initial begin
    exp_t r;
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    r.pc = 32'h0; r.valid = 0; r.pend = 0; r.cause = 0; r.epc = 0; r.cnt = 0;
    compareAll("reset", r);
    rst_n = 1'b1;
    check("boot_valid", {31'b0, pcValid}, 32'd0);
    //    tag        j  jt            b  bt            st h  r  a  pc            v  p  c      epc     cnt
    step("boot",     0, 0,            0, 0,            0, 0, 0, 0, 32'h0,        1, 0, 2'b00, 32'h0,  0);
    step("seq4",     0, 0,            0, 0,            0, 0, 0, 0, 32'h4,        1, 0, 2'b00, 32'h0,  1);
    step("seq8",     0, 0,            0, 0,            0, 0, 0, 0, 32'h8,        1, 0, 2'b00, 32'h0,  2);
    step("seq12",    0, 0,            0, 0,            0, 0, 0, 0, 32'hC,        1, 0, 2'b00, 32'h0,  3);
    step("seq16",    0, 0,            0, 0,            0, 0, 0, 0, 32'h10,       1, 0, 2'b00, 32'h0,  4);
    step("stall1",   0, 0,            1, 32'h40,       1, 0, 0, 0, 32'h10,       1, 0, 2'b00, 32'h0,  4);
    step("stall2",   0, 0,            1, 32'h40,       1, 1, 0, 0, 32'h10,       1, 0, 2'b00, 32'h0,  4);
    step("stall3",   0, 0,            1, 32'h42,       1, 0, 0, 0, 32'h10,       1, 0, 2'b00, 32'h0,  4);
    step("jmp20",    1, 32'h20,       0, 0,            0, 0, 0, 0, 32'h20,       1, 0, 2'b00, 32'h0,  5);
    step("prio",     1, 32'h80,       1, 32'h40,       0, 0, 0, 0, 32'h80,       1, 0, 2'b00, 32'h0,  6);
    step("br30",     0, 0,            1, 32'h30,       0, 0, 0, 0, 32'h30,       1, 0, 2'b00, 32'h0,  7);
    step("trapbr",   0, 0,            1, 32'h42,       0, 1, 0, 0, 32'h100,      1, 1, 2'b01, 32'h30, 7);
    step("inTrap",   0, 0,            0, 0,            0, 0, 0, 0, 32'h104,      1, 1, 2'b01, 32'h30, 8);
    step("ack",      0, 0,            0, 0,            0, 0, 0, 1, 32'h108,      1, 0, 2'b00, 32'h30, 9);
    step("jmp50",    1, 32'h50,       0, 0,            0, 0, 0, 0, 32'h50,       1, 0, 2'b00, 32'h30, 10);
    step("halt",     0, 0,            0, 0,            0, 1, 0, 0, 32'h50,       0, 0, 2'b00, 32'h30, 11);
    step("halted",   1, 32'h90,       0, 0,            1, 0, 0, 0, 32'h50,       0, 0, 2'b00, 32'h30, 11);
    step("resume",   0, 0,            0, 0,            0, 0, 1, 0, 32'h54,       1, 0, 2'b00, 32'h30, 11);
    step("trapjmp",  1, 32'h33,       0, 0,            0, 0, 0, 0, 32'h100,      1, 1, 2'b10, 32'h54, 11);
    step("nested",   0, 0,            1, 32'h61,       0, 0, 0, 0, 32'h61,       1, 0, 2'b00, 32'h54, -1);
    step("jmpTop",   1, 32'hFFFFFFFC, 0, 0,            0, 0, 0, 0, 32'hFFFFFFFC, 1, 0, 2'b00, 32'h54, -1);
    step("wrap",     0, 0,            0, 0,            0, 0, 0, 0, 32'h0,        1, 0, 2'b00, 32'h54, -1);
    step("trapEnd",  1, 32'h6,        0, 0,            0, 0, 0, 0, 32'h100,      1, 1, 2'b10, 32'h0,  -1);
    #2 rst_n = 1'b0;
    #1;
    r.pc = 32'h0; r.valid = 0; r.pend = 0; r.cause = 0; r.epc = 0; r.cnt = 0;
    compareAll("asyncRst", r);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Program counter register and next-PC selection stage for the single-cycle RV32I core. It sits directly upstream and downstream of `pcplus4`: it drives the current PC into `pcplus4` and instruction memory, and each cycle it consumes `pcplus4`'s `NexttoPc` result or a branch/jump target. It also handles stalls, halt/resume and misaligned-target traps through a small state machine.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset.
- `TRAP_VECTOR`, default 32'h0000_0100: PC value loaded on a misaligned-target trap.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `NexttoPc` input 32: sequential next PC (PC+4) from `pcplus4`.
- `branchTaken` input 1: conditional branch resolved taken this cycle.
- `branchTarget` input 32: branch target address.
- `jumpTaken` input 1: JAL/JALR this cycle. The datapath has already cleared bit0 for JALR.
- `jumpTarget` input 32: jump target address.
- `stall` input 1: hold the PC this cycle.
- `halt` input 1: ECALL/EBREAK retired; stop fetching.
- `resume` input 1: leave the halted state.
- `trapAck` input 1: trap handler acknowledges the pending trap.
- `fromPc` output 32: current PC, to `pcplus4` and instruction memory.
- `pcValid` output 1: current PC holds a fetchable instruction.
- `trapPending` output 1: misaligned-target trap outstanding.
- `trapCause` output 2: 2'b01 branch misaligned, 2'b10 jump misaligned, 2'b00 none.
- `trapEpc` output 32: PC of the instruction that caused the trap.
- `retireCount` output 32: retired-instruction counter. Present only with `PC_PERF_CNT_EN`.

## Operation
- The state machine has four states: BOOT, RUN, HALTED, TRAP.
- Reset, asynchronous, any state:
  - State goes to BOOT and `fromPc` = `RESET_VECTOR`.
  - `pcValid`=0, `trapPending`=0, `trapCause`=0, `trapEpc`=0, `retireCount`=0.
- BOOT:
  - Moves to RUN unconditionally on the next edge; the PC is held.
  - `pcValid`=0 while in BOOT.
- RUN (`pcValid`=1). Candidate next PC, in priority order:
  - `jumpTaken` → `jumpTarget`.
  - else `branchTaken` → `branchTarget`.
  - else `NexttoPc`.
- RUN, checks applied to the candidate in priority order:
  - `stall`=1: PC, state and counter hold, and all other inputs are ignored.
  - Candidate[1:0] ≠ 2'b00 (jump or branch only): go to TRAP. Set `fromPc`=`TRAP_VECTOR`, `trapEpc`=old PC, `trapCause` per source, `trapPending`=1. The faulting instruction does not retire.
  - `halt`=1: go to HALTED. PC holds at the halt instruction. The halt instruction retires.
  - Otherwise: PC loads the candidate and the instruction retires (counter +1).
- Trap versus halt: if misalignment and `halt` occur in the same cycle, the trap wins.
- TRAP:
  - `pcValid`=1; the handler fetches from `TRAP_VECTOR` onward with normal sequencing.
  - `trapAck`=1: go to RUN and clear `trapPending` and `trapCause`. `trapEpc` holds until the next trap.
  - A further misaligned target while in TRAP also clears the pending trap and goes to RUN. No nested trap is raised; the new target is loaded unchecked.
- HALTED:
  - `pcValid`=0 and the PC holds.
  - `resume`=1: go to RUN with PC = `NexttoPc` (the instruction after the halt).
  - `stall` is ignored in this state.
- Arithmetic: 32-bit and unsigned. The PC wraps 32'hFFFF_FFFC → 32'h0000_0000 via `NexttoPc` with no flag. `retireCount` wraps 32'hFFFF_FFFF → 0.

## Timing
- All outputs are registered and update only on the rising `clk` edge. The exception is reset, which forces reset values immediately on `rst_n` falling.
- Redirect latency is 1 cycle: the target is on `fromPc` the cycle after `jumpTaken` or `branchTaken` is sampled.
- BOOT lasts exactly one cycle after `rst_n` deasserts, so the first valid fetch is on the second edge.
- `trapPending` rises on the same edge that loads `TRAP_VECTOR`.
- `rst_n` deassertion is synchronised externally; the block does not re-synchronise it.

## Configuration
- `PC_PERF_CNT_EN` defined:
  - `retireCount` port exists.
  - It increments by 1 on each retiring RUN/TRAP cycle, meaning not stalled and not faulting.
  - A retiring `halt` also counts.
- `PC_PERF_CNT_EN` undefined:
  - The port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset and sequential run: `RESET_VECTOR`=0, release `rst_n`, feed `NexttoPc`=`fromPc`+4. Expect `pcValid`=0 for 1 cycle, then `fromPc` = 0, 4, 8, 12. With the macro, `retireCount`=3 after 3 retiring cycles.
- Redirect priority: `fromPc`=0x20, `jumpTaken`=1 with 0x80, `branchTaken`=1 with 0x40 in the same cycle. Next `fromPc`=0x80.
- Stall: `stall`=1 for 3 cycles at `fromPc`=0x10 with `branchTaken`=1. `fromPc` stays 0x10 and the counter is unchanged.
- Misaligned trap: at `fromPc`=0x30, `branchTaken`=1 with `branchTarget`=0x42, and `halt`=1 in the same cycle.
  - Expect `fromPc`=0x100, `trapPending`=1, `trapCause`=2'b01, `trapEpc`=0x30.
  - Then `trapAck` gives state RUN with `trapPending`=0.
- Halt/resume: `halt` at `fromPc`=0x50 gives `pcValid`=0 with `fromPc` held at 0x50. `resume`=1 with `NexttoPc`=0x54 gives `fromPc`=0x54 and `pcValid`=1.
- Async reset mid-trap: drop `rst_n` while in TRAP, between edges. Outputs go to reset values immediately: `fromPc`=`RESET_VECTOR`, `trapPending`=0.
